// File: rtl/im_fetch_server_pkg.sv
// Shared constants and state encoding for the instruction-memory fetch server.
package im_fetch_server_pkg;

    localparam logic [31:0] IFS_NOP      = 32'h0000_0000;
    localparam logic [31:0] IFS_RESET_PC = 32'h0000_3000;

    typedef enum logic {
        IFS_IDLE = 1'b0,
        IFS_BUSY = 1'b1
    } ifs_state_t;

endpackage

// File: rtl/im_line_buf.sv
// Direct-mapped instruction line storage: combinational read, synchronous write.
// Only the valid bits are reset or invalidated; tag/data are don't-care while invalid.
module im_line_buf #(
    parameter int ENTRIES = 4,
    parameter int IW      = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inv,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_valid,
    output logic [29:0]   rd_tag,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [29:0]   wr_tag,
    input  logic [31:0]   wr_data
);

    logic [ENTRIES-1:0] valid;
    logic [29:0]        tag_mem  [ENTRIES];
    logic [31:0]        data_mem [ENTRIES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (inv) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/im_fetch_server.sv
// Fetch-side instruction responder: buffer hit or ack bypass returns a word, otherwise stalls Fetch.
// One outstanding bus read; a redirect or invalidate mid-read marks the ack to be drained unused.
module im_fetch_server
    import im_fetch_server_pkg::*;
#(
    parameter int          ENTRIES  = 4,
    parameter logic [31:0] NOP_WORD = IFS_NOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] f_PC,
    input  logic        f_AdEL,
    input  logic        Req,
    input  logic        inv,
    output logic [31:0] Instr_out,
    output logic        f_stall,
    output logic        i_req,
    output logic [31:0] i_addr,
    input  logic        i_ack,
    input  logic [31:0] i_rdata
);

    localparam int IW = $clog2(ENTRIES);

    ifs_state_t  state;
    ifs_state_t  state_nxt;
    logic [29:0] req_addr;
    logic        drop;

    logic        buf_valid;
    logic [29:0] buf_tag;
    logic [31:0] buf_data;
    logic        hit;
    logic        ack_ok;
    logic        bypass;
    logic        launch;
    logic [1:0]  unused_pc_lsb;

    assign unused_pc_lsb = f_PC[1:0];

    im_line_buf #(
        .ENTRIES (ENTRIES),
        .IW      (IW)
    ) u_line_buf (
        .clk      (clk),
        .reset    (reset),
        .inv      (inv),
        .rd_idx   (f_PC[IW+1:2]),
        .rd_valid (buf_valid),
        .rd_tag   (buf_tag),
        .rd_data  (buf_data),
        .wr_en    (ack_ok),
        .wr_idx   (req_addr[IW-1:0]),
        .wr_tag   (req_addr),
        .wr_data  (i_rdata)
    );

    assign hit    = buf_valid && (buf_tag == f_PC[31:2]);
    // An ack is only usable if no redirect/invalidate happened during or alongside it.
    assign ack_ok = (state == IFS_BUSY) && i_ack && !drop && !Req && !inv;
    assign bypass = ack_ok && (req_addr == f_PC[31:2]);
    assign launch = (state == IFS_IDLE) && !hit && !f_AdEL && !Req && !inv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IFS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IFS_IDLE: if (launch) state_nxt = IFS_BUSY;
            IFS_BUSY: if (i_ack)  state_nxt = IFS_IDLE;
            default:              state_nxt = IFS_IDLE;
        endcase
    end

    always_comb begin
        Instr_out = NOP_WORD;
        f_stall   = 1'b0;
        if (!reset && !f_AdEL) begin
            if (hit) begin
                Instr_out = buf_data;
            end else if (bypass) begin
                Instr_out = i_rdata;
            end else begin
                f_stall = 1'b1;
            end
        end
        i_req  = (state == IFS_BUSY);
        i_addr = {req_addr, 2'b00};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_addr <= IFS_RESET_PC[31:2];
            drop     <= 1'b0;
        end else begin
            if (launch) begin
                req_addr <= f_PC[31:2];
            end
            if (state == IFS_BUSY) begin
                if (i_ack) begin
                    drop <= 1'b0;
                end else if (Req || inv) begin
                    drop <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_im_fetch_server.sv
// Directed bench for im_fetch_server: per-cycle expectations queued by stimulus, checked by a negedge monitor.
module tb_im_fetch_server;
    import im_fetch_server_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] f_pc;
    logic        f_adel;
    logic        req;
    logic        inv_s;
    logic [31:0] instr_out;
    logic        f_stall;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;

    im_fetch_server #(
        .ENTRIES  (4),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .f_PC      (f_pc),
        .f_AdEL    (f_adel),
        .Req       (req),
        .inv       (inv_s),
        .Instr_out (instr_out),
        .f_stall   (f_stall),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata)
    );

    typedef struct {
        string       nm;
        logic        stall;
        logic [31:0] instr;
        logic        ireq;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] a;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] A0  = IFS_RESET_PC;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic [31:0] addr);
        return {16'hC0DE, addr[15:0]};
    endfunction

    task automatic cmp(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s.%s: got %h want %h", nm, fld, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            cmp(mon_e.nm, "f_stall", {31'b0, f_stall}, {31'b0, mon_e.stall});
            cmp(mon_e.nm, "Instr_out", instr_out, mon_e.instr);
            cmp(mon_e.nm, "i_req", {31'b0, i_req}, {31'b0, mon_e.ireq});
            if (mon_e.ireq) cmp(mon_e.nm, "i_addr", i_addr, mon_e.addr);
        end
    end

    // Drives one cycle of inputs, queues its expected outputs, then advances to just after the next edge.
    task automatic step(input logic [31:0] pc, input logic adel, input logic rq, input logic iv,
                        input logic ack, input logic exp_stall, input logic [31:0] exp_instr,
                        input logic exp_ireq, input logic [31:0] exp_addr, input string nm);
        exp_t e;
        f_pc    = pc;
        f_adel  = adel;
        req     = rq;
        inv_s   = iv;
        i_ack   = ack;
        i_rdata = ack ? w(exp_addr) : 32'hDEAD_BEEF;
        e.nm    = nm;
        e.stall = exp_stall;
        e.instr = exp_instr;
        e.ireq  = exp_ireq;
        e.addr  = exp_addr;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic miss(input logic [31:0] pc, input string nm);
        step(pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NOP, 1'b0, 32'h0, nm);
    endtask

    task automatic wt(input logic [31:0] pc, input logic [31:0] ba, input string nm);
        step(pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NOP, 1'b1, ba, nm);
    endtask

    task automatic fill(input logic [31:0] pc, input string nm);
        step(pc, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, w(pc), 1'b1, pc, nm);
    endtask

    task automatic hit(input logic [31:0] pc, input string nm);
        step(pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w(pc), 1'b0, 32'h0, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        f_pc    = A0;
        f_adel  = 1'b0;
        req     = 1'b0;
        inv_s   = 1'b0;
        i_ack   = 1'b0;
        i_rdata = 32'h0;
        @(posedge clk);
        #1;

        // reset state
        step(A0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NOP, 1'b0, 32'h0, "reset0");
        step(A0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NOP, 1'b0, 32'h0, "reset1");
        reset = 1'b0;

        // cold miss, ack two cycles after i_req rises -> three stall cycles
        miss(A0, "cold_miss");
        wt(A0, A0, "cold_w1");
        wt(A0, A0, "cold_w2");
        fill(A0, "cold_byp");
        hit(A0, "cold_hit0");
        hit(A0, "cold_hit1");

        // sequential fills with zero-delay ack, then a stall-free second pass
        for (int i = 1; i < 4; i++) begin
            a = A0 + 32'(4 * i);
            miss(a, "seq_miss");
            fill(a, "seq_fill");
        end
        for (int i = 0; i < 4; i++) begin
            a = A0 + 32'(4 * i);
            hit(a, "seq_hit");
        end

        // same-index conflict replaces the tag
        miss(32'h3010, "conf_miss_10");
        fill(32'h3010, "conf_fill_10");
        hit(32'h3010, "conf_hit_10");
        hit(32'h3004, "conf_other");
        miss(32'h3000, "conf_miss_00");
        fill(32'h3000, "conf_fill_00");
        hit(32'h3000, "conf_hit_00");
        miss(32'h3010, "conf_miss_10b");
        fill(32'h3010, "conf_fill_10b");

        // redirect during a three-cycle wait: old ack drained, no fill, then fresh request
        miss(32'h3020, "drop_miss");
        step(32'h4180, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, NOP, 1'b1, 32'h3020, "drop_req");
        wt(32'h4180, 32'h3020, "drop_w2");
        wt(32'h4180, 32'h3020, "drop_w3");
        step(32'h4180, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, NOP, 1'b1, 32'h3020, "drop_ack");
        miss(32'h4180, "drop_relaunch");
        fill(32'h4180, "drop_fill");
        hit(32'h4180, "drop_hit");
        miss(32'h3020, "drop_old_invalid");
        fill(32'h3020, "drop_old_fill");

        // address error: NOP without stall, even where the tag would hit
        step(32'h3002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NOP, 1'b0, 32'h0, "adel_3002");
        step(32'h3006, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NOP, 1'b0, 32'h0, "adel_3006");

        // Req together with i_ack: discard, no bypass, back to IDLE
        miss(32'h3030, "rqack_miss");
        step(32'h3030, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, NOP, 1'b1, 32'h3030, "rqack");
        miss(32'h3030, "rqack_nofill");
        fill(32'h3030, "rqack_fill");

        // inv in IDLE clears everything; inv with i_ack discards
        hit(32'h3030, "pre_inv");
        step(32'h3030, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, w(32'h3030), 1'b0, 32'h0, "inv_idle");
        miss(32'h3030, "inv_cleared");
        fill(32'h3030, "inv_refill");
        miss(32'h3004, "inv_cleared2");
        step(32'h3004, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, NOP, 1'b1, 32'h3004, "inv_ack");
        miss(32'h3004, "inv_ack_nofill");
        fill(32'h3004, "inv_ack_fill");
        hit(32'h3004, "inv_ack_hit");

        // asynchronous reset in BUSY, then a stray ack in IDLE
        miss(32'h3008, "rst_miss");
        wt(32'h3008, 32'h3008, "rst_wait");
        reset = 1'b1;
        step(32'h3008, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NOP, 1'b0, 32'h0, "rst_mid");
        reset = 1'b0;
        step(32'h3004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, NOP, 1'b0, 32'h0, "rst_stray");
        fill(32'h3004, "rst_refill");
        miss(A0, "rst_3000");
        fill(A0, "rst_3000_fill");

        for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
